// File: rtl/pause_frame_sync.sv
// -----------------------------------------------------------------------------
// pause_frame_sync
//
// Purpose:
//   Freezes the core CPU on a frame boundary. A pause request moves the FSM
//   to a pending state that waits for the next vblank rising edge, or for a
//   timeout, before gating the CPU clock enable. While paused, an optional
//   step request lets the core run for STEP_FRAMES vblank edges and then
//   freezes it again.
//
// Parameters:
//   STEP_FRAMES  vblank rising edges run per step request (1..255)
//   TIMEOUT      clk_sys cycles to wait in PEND before forcing the pause
//
// Ports:
//   clk_sys      in   core system clock
//   reset        in   asynchronous active-high reset
//   ce_in        in   core CPU clock enable
//   pause_cpu    in   pause request (active-high)
//   vblank       in   vertical blank (active-high, clk_sys domain)
//   step_button  in   single-frame advance request (active-high)
//   ce_out       out  gated CPU clock enable (combinational from ce_in)
//   paused       out  high while the CPU is frozen
//   state_out    out  FSM state: 0=RUN 1=PEND 2=PAUSED 3=STEP
//
// Configuration macro:
//   PAUSE_FRAME_STEP_EN  when defined, builds the STEP state, the frame
//                        counter and the step_button handling. When
//                        undefined, step_button is ignored and state_out
//                        never reads 3.
// -----------------------------------------------------------------------------
module pause_frame_sync #(
   parameter int          STEP_FRAMES = 1,
   parameter logic [23:0] TIMEOUT     = 24'd12000000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce_in,
   input  logic       pause_cpu,
   input  logic       vblank,
   input  logic       step_button,
   output logic       ce_out,
   output logic       paused,
   output logic [1:0] state_out
);

   localparam logic [1:0]  S_RUN        = 2'd0;
   localparam logic [1:0]  S_PEND       = 2'd1;
   localparam logic [1:0]  S_PAUSED     = 2'd2;
   localparam logic [1:0]  S_STEP       = 2'd3;
   localparam logic [23:0] TIMEOUT_LAST = TIMEOUT - 24'd1;
   localparam logic [23:0] TIMEOUT_SAT  = 24'hFFFFFF;

   logic [1:0]  r_state;
   logic [1:0]  w_nextState;
   logic        r_runEn;
   logic        r_vblankPrev;
   logic        r_stepPrev;
   logic [23:0] r_timeout;
   logic        w_vblankEdge;
   logic        w_timeoutHit;
   logic        w_enterPend;

   assign w_vblankEdge = vblank & ~r_vblankPrev;
   assign w_timeoutHit = (r_timeout == TIMEOUT_LAST);
   assign w_enterPend  = (r_state != S_PEND) && (w_nextState == S_PEND);

`ifdef PAUSE_FRAME_STEP_EN
   localparam logic [7:0] STEP_TARGET = 8'(STEP_FRAMES);

   logic [7:0] r_frameCnt;
   logic [7:0] w_frameNext;
   logic       w_stepEdge;
   logic       w_stepDone;
   logic       w_enterStep;

   assign w_stepEdge  = step_button & ~r_stepPrev;
   assign w_frameNext = r_frameCnt + 8'd1;
   // The step ends on the vblank edge that brings the count up to the target,
   // so the comparison looks at the value the counter is about to take.
   assign w_stepDone  = w_vblankEdge && (w_frameNext == STEP_TARGET);
   assign w_enterStep = (r_state != S_STEP) && (w_nextState == S_STEP);

   // Frame counter: restarts from zero every time STEP is entered and counts
   // vblank edges seen while stepping.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_frameCnt <= 8'd0;
      end else if (w_enterStep) begin
         r_frameCnt <= 8'd0;
      end else if ((r_state == S_STEP) && w_vblankEdge) begin
         r_frameCnt <= w_frameNext;
      end
   end
`else
   // Without stepping, the step edge register and STEP_FRAMES have no load;
   // they are collected here so the build stays free of dangling signals.
   logic [8:0] w_unusedStep;
   assign w_unusedStep = {8'(STEP_FRAMES), step_button & ~r_stepPrev};
`endif

   // Next-state logic. Releasing pause_cpu always wins over any same-cycle
   // vblank or step event, so a late cancel never produces a paused frame.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_RUN: begin
            if (pause_cpu) begin
               w_nextState = S_PEND;
            end
         end
         S_PEND: begin
            if (!pause_cpu) begin
               w_nextState = S_RUN;
            end else if (w_vblankEdge || w_timeoutHit) begin
               w_nextState = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (!pause_cpu) begin
               w_nextState = S_RUN;
            end
`ifdef PAUSE_FRAME_STEP_EN
            else if (w_stepEdge) begin
               w_nextState = S_STEP;
            end
`endif
         end
`ifdef PAUSE_FRAME_STEP_EN
         S_STEP: begin
            if (!pause_cpu) begin
               w_nextState = S_RUN;
            end else if (w_stepDone) begin
               w_nextState = S_PAUSED;
            end
         end
`endif
         default: begin
            w_nextState = S_RUN;
         end
      endcase
   end

   // State, run enable and edge-detect history. run_en is registered from the
   // next state so it drops in exactly the same cycle the state reads PAUSED.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state      <= S_RUN;
         r_runEn      <= 1'b1;
         r_vblankPrev <= 1'b0;
         r_stepPrev   <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_runEn      <= (w_nextState != S_PAUSED);
         r_vblankPrev <= vblank;
         r_stepPrev   <= step_button;
      end
   end

   // Timeout counter: zeroed as PEND is entered, then counts every cycle in
   // PEND and sticks at all-ones rather than wrapping back to zero.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_timeout <= 24'd0;
      end else if (w_enterPend) begin
         r_timeout <= 24'd0;
      end else if ((r_state == S_PEND) && (r_timeout != TIMEOUT_SAT)) begin
         r_timeout <= r_timeout + 24'd1;
      end
   end

   assign ce_out    = ce_in & r_runEn;
   assign paused    = ~r_runEn;
   assign state_out = r_state;

endmodule

// File: tb/tb_pause_frame_sync.sv
// -----------------------------------------------------------------------------
// tb_pause_frame_sync
//
// Purpose:
//   Self-checking bench for pause_frame_sync, built with STEP_FRAMES=2 and
//   TIMEOUT=100. Each scenario task drives one stimulus pattern cycle by
//   cycle, pushes the outputs it expects for that cycle into a scoreboard
//   queue, and pops and compares them on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pause_frame_sync;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_PEND   = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_STEP   = 2'd3;

   typedef struct packed {
      logic [1:0] st;
      logic       pa;
      logic       ce;
   } exp_t;

   logic       clk_sys;
   logic       reset;
   logic       ce_in;
   logic       pause_cpu;
   logic       vblank;
   logic       step_button;
   logic       ce_out;
   logic       paused;
   logic [1:0] state_out;

   exp_t sbQ[$];
   int   total;
   int   bad;

   pause_frame_sync #(
      .STEP_FRAMES(2),
      .TIMEOUT    (24'd100)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ce_in      (ce_in),
      .pause_cpu  (pause_cpu),
      .vblank     (vblank),
      .step_button(step_button),
      .ce_out     (ce_out),
      .paused     (paused),
      .state_out  (state_out)
   );

   // 10 ns system clock.
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Drives one cycle's inputs shortly after the rising edge.
   task automatic applyStimulus(input logic p, input logic v, input logic s, input logic c);
      @(posedge clk_sys);
      #1;
      pause_cpu   = p;
      vblank      = v;
      step_button = s;
      ce_in       = c;
   endtask

   // Quiet cycles between scenarios so every test starts from RUN.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   // Asynchronous reset: outputs take reset values without a clock edge.
   task automatic test_reset();
      exp_t e;
      reset       = 1'b1;
      ce_in       = 1'b1;
      pause_cpu   = 1'b0;
      vblank      = 1'b0;
      step_button = 1'b0;
      #3;
      sbQ.push_back('{st: ST_RUN, pa: 1'b0, ce: 1'b1});
      e = sbQ.pop_front();
      total++;
      if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
         bad++;
         $display("[TB] FAIL reset_ce1 got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                  state_out, paused, ce_out, e.st, e.pa, e.ce);
      end
      ce_in = 1'b0;
      sbQ.push_back('{st: ST_RUN, pa: 1'b0, ce: 1'b0});
      #1;
      e = sbQ.pop_front();
      total++;
      if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
         bad++;
         $display("[TB] FAIL reset_ce0 got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                  state_out, paused, ce_out, e.st, e.pa, e.ce);
      end
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      ce_in = 1'b1;
   endtask

   // pause_cpu at cycle 10, vblank edge at cycle 50, release at cycle 61.
   task automatic test_pause_vblank();
      exp_t e;
      for (int cyc = 0; cyc <= 63; cyc++) begin
         applyStimulus(cyc >= 10 && cyc <= 60, cyc >= 50, 1'b0, 1'b1);
         e.st = (cyc >= 62) ? ST_RUN : (cyc >= 51) ? ST_PAUSED : (cyc >= 11) ? ST_PEND : ST_RUN;
         e.pa = (e.st == ST_PAUSED);
         e.ce = !e.pa;
         sbQ.push_back(e);
         @(negedge clk_sys);
         e = sbQ.pop_front();
         total++;
         if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
            bad++;
            $display("[TB] FAIL pause_vblank cyc=%0d got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                     cyc, state_out, paused, ce_out, e.st, e.pa, e.ce);
         end
      end
   endtask

   // In PEND, pause_cpu drops in the same cycle as a vblank edge.
   task automatic test_cancel();
      exp_t e;
      logic c;
      for (int cyc = 0; cyc <= 12; cyc++) begin
         c = (cyc % 2) == 0;
         applyStimulus(cyc >= 2 && cyc <= 7, cyc >= 8, 1'b0, c);
         e.st = (cyc >= 3 && cyc <= 8) ? ST_PEND : ST_RUN;
         e.pa = 1'b0;
         e.ce = c;
         sbQ.push_back(e);
         @(negedge clk_sys);
         e = sbQ.pop_front();
         total++;
         if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
            bad++;
            $display("[TB] FAIL cancel cyc=%0d got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                     cyc, state_out, paused, ce_out, e.st, e.pa, e.ce);
         end
      end
   endtask

   // No vblank: PEND entered at cycle 1, forced pause 100 cycles later.
   task automatic test_timeout();
      exp_t e;
      logic c;
      for (int cyc = 0; cyc <= 104; cyc++) begin
         c = (cyc % 2) == 1;
         applyStimulus(1'b1, 1'b0, 1'b0, c);
         e.st = (cyc >= 101) ? ST_PAUSED : (cyc >= 1) ? ST_PEND : ST_RUN;
         e.pa = (e.st == ST_PAUSED);
         e.ce = c & !e.pa;
         sbQ.push_back(e);
         @(negedge clk_sys);
         e = sbQ.pop_front();
         total++;
         if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
            bad++;
            $display("[TB] FAIL timeout cyc=%0d got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                     cyc, state_out, paused, ce_out, e.st, e.pa, e.ce);
         end
      end
   endtask

   // One-cycle reset pulse while PAUSED with pause_cpu still held.
   task automatic test_reset_paused();
      exp_t e;
      @(posedge clk_sys);
      #1;
      reset = 1'b1;
      ce_in = 1'b1;
      sbQ.push_back('{st: ST_RUN, pa: 1'b0, ce: 1'b1});
      #1;
      e = sbQ.pop_front();
      total++;
      if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
         bad++;
         $display("[TB] FAIL rst_paused_imm got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                  state_out, paused, ce_out, e.st, e.pa, e.ce);
      end
      ce_in = 1'b0;
      sbQ.push_back('{st: ST_RUN, pa: 1'b0, ce: 1'b0});
      #1;
      e = sbQ.pop_front();
      total++;
      if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
         bad++;
         $display("[TB] FAIL rst_paused_ce0 got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                  state_out, paused, ce_out, e.st, e.pa, e.ce);
      end
      ce_in = 1'b1;
      @(posedge clk_sys);
      #1;
      reset = 1'b0;
      sbQ.push_back('{st: ST_RUN, pa: 1'b0, ce: 1'b1});
      @(negedge clk_sys);
      e = sbQ.pop_front();
      total++;
      if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
         bad++;
         $display("[TB] FAIL rst_deassert got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                  state_out, paused, ce_out, e.st, e.pa, e.ce);
      end
      @(posedge clk_sys);
      #1;
      sbQ.push_back('{st: ST_PEND, pa: 1'b0, ce: 1'b1});
      e = sbQ.pop_front();
      total++;
      if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
         bad++;
         $display("[TB] FAIL rst_first_edge got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                  state_out, paused, ce_out, e.st, e.pa, e.ce);
      end
   endtask

`ifdef PAUSE_FRAME_STEP_EN
   // Pause on vblank at cycle 3, step at 10 with vblank edges at 30 and 50,
   // ignored steps at 2 (PEND) and 40 (STEP), second step at 56, release at 60.
   task automatic test_step_frames();
      exp_t e;
      logic c;
      for (int cyc = 0; cyc <= 63; cyc++) begin
         c = (cyc % 3) != 0;
         applyStimulus(cyc <= 59, cyc == 3 || cyc == 30 || cyc == 50,
                       cyc == 2 || cyc == 10 || cyc == 40 || cyc == 56, c);
         if (cyc == 0)                   e.st = ST_RUN;
         else if (cyc <= 3)              e.st = ST_PEND;
         else if (cyc <= 10)             e.st = ST_PAUSED;
         else if (cyc <= 50)             e.st = ST_STEP;
         else if (cyc <= 56)             e.st = ST_PAUSED;
         else if (cyc <= 60)             e.st = ST_STEP;
         else                            e.st = ST_RUN;
         e.pa = (e.st == ST_PAUSED);
         e.ce = c & !e.pa;
         sbQ.push_back(e);
         @(negedge clk_sys);
         e = sbQ.pop_front();
         total++;
         if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
            bad++;
            $display("[TB] FAIL step_frames cyc=%0d got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                     cyc, state_out, paused, ce_out, e.st, e.pa, e.ce);
         end
      end
   endtask
`else
   // Same stimulus as the stepping build: step pulses must not disturb PAUSED.
   task automatic test_step_ignored();
      exp_t e;
      logic c;
      for (int cyc = 0; cyc <= 63; cyc++) begin
         c = (cyc % 3) != 0;
         applyStimulus(cyc <= 59, cyc == 3 || cyc == 30 || cyc == 50,
                       cyc == 2 || cyc == 10 || cyc == 40 || cyc == 56, c);
         if (cyc == 0)       e.st = ST_RUN;
         else if (cyc <= 3)  e.st = ST_PEND;
         else if (cyc <= 60) e.st = ST_PAUSED;
         else                e.st = ST_RUN;
         e.pa = (e.st == ST_PAUSED);
         e.ce = c & !e.pa;
         sbQ.push_back(e);
         @(negedge clk_sys);
         e = sbQ.pop_front();
         total++;
         if ({state_out, paused, ce_out} !== {e.st, e.pa, e.ce}) begin
            bad++;
            $display("[TB] FAIL step_ignored cyc=%0d got st=%0d paused=%0b ce=%0b want st=%0d paused=%0b ce=%0b",
                     cyc, state_out, paused, ce_out, e.st, e.pa, e.ce);
         end
      end
   endtask
`endif

   // Scenario sequence.
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      idle(3);
      test_pause_vblank();
      idle(3);
      test_cancel();
      idle(3);
      test_timeout();
      test_reset_paused();
      idle(3);
`ifdef PAUSE_FRAME_STEP_EN
      test_step_frames();
`else
      test_step_ignored();
`endif
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
